// File: rtl/data_mem_sized.sv
// data_mem_sized: byte-addressed, word-organised data RAM for the MEM stage.
// Supports byte/half/word loads and stores with sign or zero extension, a
// programmable access latency and a ready/error completion handshake.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  edges from request acceptance to ready (1..15)
//   ADDR_W   byte address width
// Ports
//   clk, reset_n            clock, async active-low reset
//   address                 byte address, captured at acceptance
//   writeData               right-aligned store data
//   memWrite, memRead       store / load request
//   memSize                 00 byte, 01 half, 10 word, 11 illegal
//   memUnsigned             1 = zero-extend loads
//   readData                extended load result (held between loads)
//   ready                   one-cycle completion pulse
//   busy                    request in flight
//   error                   faulted access, qualified by ready

// One byte lane of the RAM: a DEPTH x 8 array with its own write enable.
module data_mem_sized_lane #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wData,
  output logic [7:0]       rData
);
  logic [7:0] ram [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk)
    if (we) ram[idx] <= wData;

  assign rData = ram[idx];
endmodule

module data_mem_sized #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writeData,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [1:0]        memSize,
  input  logic              memUnsigned,
  output logic [31:0]       readData,
  output logic              ready,
  output logic              busy,
  output logic              error
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              uns;
    logic              rd;
    logic              wr;
  } memReq_t;

  state_t  state;
  memReq_t req;
  logic [3:0] cnt;

  logic oob, fault, doWrite;
  logic [NUM_LANES-1:0]       laneEn;
  logic [NUM_LANES-1:0][7:0]  wLaneData;
  logic [NUM_LANES-1:0][7:0]  rWord;
  logic [31:0]                shifted, loadVal;

  // Word index out of range: any index bit above the RAM's index width.
  if (ADDR_W > IDX_W + 2) begin : gOob
    assign oob = |req.addr[ADDR_W-1:IDX_W+2];
  end else begin : gNoOob
    assign oob = 1'b0;
  end

  always_comb begin
    fault = oob | (req.rd & req.wr);
    case (req.size)
      2'b00:   ;
      2'b01:   if (req.addr[0]) fault = 1'b1;
      2'b10:   if (req.addr[1:0] != 2'b00) fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

  // Lane enables and lane-replicated store data, little-endian.
  always_comb begin
    laneEn = '0;
    case (req.size)
      2'b00:   laneEn[req.addr[1:0]] = 1'b1;
      2'b01:   laneEn = req.addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   laneEn = 4'b1111;
      default: laneEn = '0;
    endcase
  end

  always_comb begin
    case (req.size)
      2'b00:   wLaneData = {NUM_LANES{req.wdata[7:0]}};
      2'b01:   wLaneData = {2{req.wdata[15:0]}};
      default: wLaneData = req.wdata;
    endcase
  end

  // The write happens on the edge that leaves RESP; reset forces IDLE so an
  // aborted access never reaches this point.
  assign doWrite = (state == RESP) & req.wr & ~fault;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    data_mem_sized_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) uLane (
      .clk   (clk),
      .we    (doWrite & laneEn[g]),
      .idx   (req.addr[IDX_W+1:2]),
      .wData (wLaneData[g]),
      .rData (rWord[g])
    );
  end

  // Shift the addressed lane(s) down to bit 0, then extend.
  assign shifted = rWord >> {req.addr[1:0], 3'b000};

  always_comb begin
    case (req.size)
      2'b00:   loadVal = {{24{~req.uns & shifted[7]}},  shifted[7:0]};
      2'b01:   loadVal = {{16{~req.uns & shifted[15]}}, shifted[15:0]};
      default: loadVal = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      req      <= '0;
      cnt      <= '0;
      readData <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (memRead | memWrite) begin
            req  <= '{addr: address, wdata: writeData, size: memSize,
                      uns: memUnsigned, rd: memRead, wr: memWrite};
            busy <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          ready <= 1'b1;
          error <= fault;
          busy  <= 1'b0;
          state <= IDLE;
          // Any load (faulted or not) updates readData; stores leave it alone.
          if (req.rd) readData <= fault ? 32'h0 : loadVal;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_sized.sv
module tb_data_mem_sized;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  // Instance A: LATENCY=1, instance B: LATENCY=4; both DEPTH=64.
  logic [31:0] aAddr, aWData, aRData, bAddr, bWData, bRData;
  logic aWr, aRd, aUns, aReady, aBusy, aErr;
  logic bWr, bRd, bUns, bReady, bBusy, bErr;
  logic [1:0] aSize, bSize;

  data_mem_sized #(.DEPTH(64), .LATENCY(1), .ADDR_W(32)) dutA (
    .clk(clk), .reset_n(rstN), .address(aAddr), .writeData(aWData),
    .memWrite(aWr), .memRead(aRd), .memSize(aSize), .memUnsigned(aUns),
    .readData(aRData), .ready(aReady), .busy(aBusy), .error(aErr));

  data_mem_sized #(.DEPTH(64), .LATENCY(4), .ADDR_W(32)) dutB (
    .clk(clk), .reset_n(rstN), .address(bAddr), .writeData(bWData),
    .memWrite(bWr), .memRead(bRd), .memSize(bSize), .memUnsigned(bUns),
    .readData(bRData), .ready(bReady), .busy(bBusy), .error(bErr));

  localparam int K_ST = 0, K_LD = 1, K_NC = 2;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          kind;
    string       name;
  } exp_t;

  exp_t qA[$], qB[$];
  int checks = 0, failures = 0;
  logic [31:0] lastA = '0, lastB = '0;
  bit knownA = 1'b1, knownB = 1'b1;

  // Scoreboard for A: pop on each ready pulse.
  always @(negedge clk) begin : monA
    exp_t e;
    if (aReady) begin
      checks++;
      if (qA.size() == 0) begin
        failures++;
        $display("FAIL A_unexpected_ready got ready=1 want ready=0");
      end else begin
        e = qA.pop_front();
        if (aErr !== e.err) begin
          failures++;
          $display("FAIL A_%s_err got %0b want %0b", e.name, aErr, e.err);
        end
        if (e.kind == K_LD) begin
          checks++;
          if (aRData !== e.data) begin
            failures++;
            $display("FAIL A_%s_data got %h want %h", e.name, aRData, e.data);
          end
          lastA = e.data; knownA = 1'b1;
        end else if (e.kind == K_ST && knownA) begin
          checks++;
          if (aRData !== lastA) begin
            failures++;
            $display("FAIL A_%s_hold got %h want %h", e.name, aRData, lastA);
          end
        end else knownA = 1'b0;
      end
    end else if (rstN) begin
      checks++;
      if (aErr !== 1'b0) begin
        failures++;
        $display("FAIL A_error_without_ready got %b want 0", aErr);
      end
    end
  end

  always @(negedge clk) begin : monB
    exp_t e;
    if (bReady) begin
      checks++;
      if (qB.size() == 0) begin
        failures++;
        $display("FAIL B_unexpected_ready got ready=1 want ready=0");
      end else begin
        e = qB.pop_front();
        if (bErr !== e.err) begin
          failures++;
          $display("FAIL B_%s_err got %0b want %0b", e.name, bErr, e.err);
        end
        if (e.kind == K_LD) begin
          checks++;
          if (bRData !== e.data) begin
            failures++;
            $display("FAIL B_%s_data got %h want %h", e.name, bRData, e.data);
          end
          lastB = e.data; knownB = 1'b1;
        end else if (e.kind == K_ST && knownB) begin
          checks++;
          if (bRData !== lastB) begin
            failures++;
            $display("FAIL B_%s_hold got %h want %h", e.name, bRData, lastB);
          end
        end else knownB = 1'b0;
      end
    end else if (rstN) begin
      checks++;
      if (bErr !== 1'b0) begin
        failures++;
        $display("FAIL B_error_without_ready got %b want 0", bErr);
      end
    end
  end

  // Drive one single-cycle request, push its expectation, and return the
  // number of edges from acceptance to ready (capped at 30).
  task automatic drv(input bit sel, input bit rd, input bit wr, input logic [1:0] size,
                     input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] expData, input bit expErr, input int kind,
                     input string name, output int lat);
    exp_t e;
    e.data = expData; e.err = expErr; e.kind = kind; e.name = name;
    @(negedge clk);
    if (!sel) begin
      aAddr = addr; aWData = wdata; aRd = rd; aWr = wr; aSize = size; aUns = uns;
      qA.push_back(e);
    end else begin
      bAddr = addr; bWData = wdata; bRd = rd; bWr = wr; bSize = size; bUns = uns;
      qB.push_back(e);
    end
    @(posedge clk); #1;
    if (!sel) begin aRd = 1'b0; aWr = 1'b0; end
    else begin bRd = 1'b0; bWr = 1'b0; end
    lat = 0;
    while (((!sel && !aReady) || (sel && !bReady)) && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({aRData, aReady, aBusy, aErr} !== 35'h0) begin
      failures++;
      $display("FAIL reset_A got rd=%h rdy=%b busy=%b err=%b want all 0", aRData, aReady, aBusy, aErr);
    end
    checks++;
    if ({bRData, bReady, bBusy, bErr} !== 35'h0) begin
      failures++;
      $display("FAIL reset_B got rd=%h rdy=%b busy=%b err=%b want all 0", bRData, bReady, bBusy, bErr);
    end
  endtask

  task automatic test_word();
    int lat;
    drv(0, 0, 1, SZ_W, 0, 32'h8, 32'hDEADBEEF, 0, 0, K_ST, "st_word", lat);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL word_store_latency got %0d want 1", lat); end
    drv(0, 1, 0, SZ_W, 0, 32'h8, 0, 32'hDEADBEEF, 0, K_LD, "ld_word", lat);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL word_load_latency got %0d want 1", lat); end
  endtask

  task automatic test_subword_load();
    int lat;
    drv(0, 1, 0, SZ_B, 0, 32'hB, 0, 32'hFFFFFFDE, 0, K_LD, "ld_byte_s", lat);
    drv(0, 1, 0, SZ_B, 1, 32'hB, 0, 32'h000000DE, 0, K_LD, "ld_byte_u", lat);
    drv(0, 1, 0, SZ_B, 1, 32'h8, 0, 32'h000000EF, 0, K_LD, "ld_byte0_u", lat);
    drv(0, 1, 0, SZ_H, 0, 32'h8, 0, 32'hFFFFBEEF, 0, K_LD, "ld_half_s", lat);
    drv(0, 1, 0, SZ_H, 1, 32'h8, 0, 32'h0000BEEF, 0, K_LD, "ld_half_u", lat);
    drv(0, 1, 0, SZ_H, 0, 32'hA, 0, 32'hFFFFDEAD, 0, K_LD, "ld_half_hi", lat);
    drv(0, 1, 0, SZ_W, 1, 32'h8, 0, 32'hDEADBEEF, 0, K_LD, "ld_word_u", lat);
  endtask

  task automatic test_partial_store();
    int lat;
    drv(0, 0, 1, SZ_H, 0, 32'hA, 32'hFFFF1234, 0, 0, K_ST, "st_half", lat);
    drv(0, 1, 0, SZ_W, 0, 32'h8, 0, 32'h1234BEEF, 0, K_LD, "ld_after_half", lat);
    drv(0, 0, 1, SZ_B, 0, 32'h9, 32'hAAAAAA77, 0, 0, K_ST, "st_byte", lat);
    drv(0, 1, 0, SZ_W, 0, 32'h8, 0, 32'h123477EF, 0, K_LD, "ld_after_byte", lat);
  endtask

  task automatic test_faults();
    int lat;
    drv(0, 0, 1, SZ_W, 0, 32'h0,   32'hCAFEF00D, 0, 0, K_ST, "st_w0", lat);
    drv(0, 0, 1, SZ_W, 0, 32'h100, 32'h12345678, 0, 1, K_ST, "st_oob", lat);
    drv(0, 0, 1, SZ_B, 0, 32'h103, 32'h000000AA, 0, 1, K_ST, "st_oob_byte", lat);
    drv(0, 1, 0, SZ_W, 0, 32'h0,   0, 32'hCAFEF00D, 0, K_LD, "ld_w0_intact", lat);
    drv(0, 1, 0, SZ_W, 0, 32'h6,   0, 32'h0, 1, K_LD, "ld_misaligned_w", lat);
    drv(0, 1, 0, SZ_W, 0, 32'h8,   0, 32'h123477EF, 0, K_LD, "ld_refresh", lat);
    drv(0, 1, 0, SZ_H, 0, 32'h9,   0, 32'h0, 1, K_LD, "ld_misaligned_h", lat);
    drv(0, 1, 0, SZ_W, 0, 32'h8,   0, 32'h123477EF, 0, K_LD, "ld_refresh2", lat);
    drv(0, 1, 0, SZ_X, 0, 32'h8,   0, 32'h0, 1, K_LD, "ld_size11", lat);
    drv(0, 1, 1, SZ_W, 0, 32'h8,   32'h0, 0, 1, K_NC, "rd_and_wr", lat);
    drv(0, 1, 0, SZ_W, 0, 32'h8,   0, 32'h123477EF, 0, K_LD, "ld_after_faults", lat);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL fault_recover_latency got %0d want 1", lat); end
  endtask

  // A held request on LATENCY=1 is accepted every second edge.
  task automatic test_back_to_back();
    exp_t e;
    logic [6:0] rdy;
    e.data = 32'h123477EF; e.err = 1'b0; e.kind = K_LD; e.name = "b2b";
    @(negedge clk);
    aAddr = 32'h8; aSize = SZ_W; aUns = 1'b0; aWr = 1'b0; aRd = 1'b1;
    repeat (3) qA.push_back(e);
    rdy = '0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      rdy[k] = aReady;
      if (k == 4) aRd = 1'b0;
    end
    checks++;
    if (rdy !== 7'b0101010) begin
      failures++;
      $display("FAIL back_to_back_ready got %b want %b", rdy, 7'b0101010);
    end
  endtask

  task automatic test_latency4();
    int lat;
    exp_t e;
    logic [9:0] bsy, rdy;
    drv(1, 0, 1, SZ_W, 0, 32'h10, 32'h11223344, 0, 0, K_ST, "st_10", lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL lat4_store_latency got %0d want 4", lat); end
    drv(1, 0, 1, SZ_W, 0, 32'h14, 32'h55667788, 0, 0, K_ST, "st_14", lat);
    @(negedge clk);
    bAddr = 32'h10; bSize = SZ_W; bUns = 1'b0; bWr = 1'b0; bRd = 1'b1;
    e.err = 1'b0; e.kind = K_LD;
    e.data = 32'h11223344; e.name = "lat4_first";  qB.push_back(e);
    e.data = 32'h55667788; e.name = "lat4_second"; qB.push_back(e);
    bsy = '0; rdy = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bsy[k] = bBusy; rdy[k] = bReady;
      if (k == 1) bAddr = 32'h14;
      if (k == 5) bRd = 1'b0;
    end
    checks++;
    if (bsy !== 10'b0111101111) begin
      failures++;
      $display("FAIL lat4_busy got %b want %b", bsy, 10'b0111101111);
    end
    checks++;
    if (rdy !== 10'b1000010000) begin
      failures++;
      $display("FAIL lat4_ready got %b want %b", rdy, 10'b1000010000);
    end
  endtask

  task automatic test_reset_abort();
    int lat, nRdy;
    drv(1, 0, 1, SZ_W, 0, 32'h0, 32'hA5A5A5A5, 0, 0, K_ST, "st_prior", lat);
    @(negedge clk);
    bAddr = 32'h0; bWData = 32'h55; bSize = SZ_W; bWr = 1'b1; bRd = 1'b0;
    @(posedge clk); #1; bWr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bBusy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got %b want 1", bBusy); end
    @(negedge clk);
    rstN = 1'b0; lastA = '0; lastB = '0; knownA = 1'b1; knownB = 1'b1;
    #1;
    checks++;
    if ({bRData, bReady, bBusy, bErr} !== 35'h0) begin
      failures++;
      $display("FAIL abort_reset_state got rd=%h rdy=%b busy=%b err=%b want all 0", bRData, bReady, bBusy, bErr);
    end
    @(negedge clk);
    rstN = 1'b1;
    nRdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bReady) nRdy++;
    end
    checks++;
    if (nRdy != 0) begin failures++; $display("FAIL abort_no_ready got %0d pulses want 0", nRdy); end
    drv(1, 1, 0, SZ_W, 0, 32'h0, 0, 32'hA5A5A5A5, 0, K_LD, "ld_after_abort", lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL abort_load_latency got %0d want 4", lat); end
    drv(0, 1, 0, SZ_W, 0, 32'h8, 0, 32'h123477EF, 0, K_LD, "A_mem_kept", lat);
  endtask

  initial begin
    rstN = 1'b0;
    aAddr = '0; aWData = '0; aWr = 0; aRd = 0; aSize = '0; aUns = 0;
    bAddr = '0; bWData = '0; bWr = 0; bRd = 0; bSize = '0; bUns = 0;
    #12;
    test_reset();
    @(negedge clk);
    rstN = 1'b1;
    test_word();
    test_subword_load();
    test_partial_store();
    test_faults();
    test_back_to_back();
    test_latency4();
    test_reset_abort();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got A=%0d B=%0d pending want 0", qA.size(), qB.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
